quad_encoder_gen: RTL and testbench

- Transmit-side counterpart of the menu's rotary-encoder decoder.
- Turns queued step commands (pushbutton or test-sequencer driven) into a clean two-phase quadrature waveform on `rota`/`rotb`.
- The decoder side consumes the waveform with its 3-stage synchronizer and XOR direction test.
- Used to drive menu selection and paddles from buttons, and as a stimulus source in system benches.

---
 rtl/quad_encoder_gen.sv | 142 ++++++++++++++
 tb/tb_quad_encoder_gen.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/quad_encoder_gen.sv
// Queued step commands in, two-phase quadrature waveform out on rota_o/rotb_o.
// Define QUAD_DETENT_EN to emit a full 4-transition detent per accepted step.
module quad_encoder_gen #(
  parameter int unsigned DWELL = 16,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clock_i,
  input  logic             reset_ni,
  input  logic             step_valid_i,
  input  logic             step_dir_i,
  output logic             step_ready_o,
  output logic             rota_o,
  output logic             rotb_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] step_count_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OccW = PtrW + 1;
  localparam logic [OccW-1:0] FullOcc = OccW'(DEPTH);
  localparam logic [15:0] DwellLoad = 16'(DWELL - 2);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StHold = 1'b1;

  logic [DEPTH-1:0] fifo_q, fifo_d;
  logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [OccW-1:0]  occ_q, occ_d;
  logic [0:0]       state_q, state_d;
  logic [1:0]       phase_q, phase_d;
  logic             rota_q, rotb_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic [15:0]      dwell_q, dwell_d;
`ifdef QUAD_DETENT_EN
  logic [1:0]       sub_q, sub_d;
`endif

  logic full, empty, push, pop, head_dir;

  assign full     = (occ_q == FullOcc);
  assign empty    = (occ_q == '0);
  assign push     = step_valid_i && !full;
  assign head_dir = fifo_q[rptr_q];

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    count_d = count_q;
    dwell_d = dwell_q;
    pop     = 1'b0;
`ifdef QUAD_DETENT_EN
    sub_d   = sub_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          phase_d = head_dir ? phase_q + 2'd1 : phase_q - 2'd1;
          count_d = count_q + CNT_W'(1);
          dwell_d = DwellLoad;
          state_d = StHold;
`ifdef QUAD_DETENT_EN
          sub_d   = sub_q + 2'd1;
`else
          pop     = 1'b1;
`endif
        end
      end
      StHold: begin
        if (dwell_q == '0) begin
          state_d = StIdle;
`ifdef QUAD_DETENT_EN
          // Sub-counter has wrapped to 0 only after the 4th transition of the detent.
          pop     = (sub_q == 2'd0);
`endif
        end else begin
          dwell_d = dwell_q - 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    fifo_d = fifo_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    occ_d  = occ_q;
    if (push) begin
      fifo_d[wptr_q] = step_dir_i;
      wptr_d         = wptr_q + PtrW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + PtrW'(1);
    end
    if (push && !pop) begin
      occ_d = occ_q + OccW'(1);
    end else if (pop && !push) begin
      occ_d = occ_q - OccW'(1);
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      fifo_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      occ_q   <= '0;
      state_q <= StIdle;
      phase_q <= 2'd0;
      rota_q  <= 1'b0;
      rotb_q  <= 1'b0;
      count_q <= '0;
      dwell_q <= '0;
`ifdef QUAD_DETENT_EN
      sub_q   <= 2'd0;
`endif
    end else begin
      fifo_q  <= fifo_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      occ_q   <= occ_d;
      state_q <= state_d;
      phase_q <= phase_d;
      // Gray mapping 0..3 -> 00,01,11,10, registered so each output is a clean flop.
      rota_q  <= phase_d[1];
      rotb_q  <= phase_d[1] ^ phase_d[0];
      count_q <= count_d;
      dwell_q <= dwell_d;
`ifdef QUAD_DETENT_EN
      sub_q   <= sub_d;
`endif
    end
  end

  assign step_ready_o = !full;
  assign rota_o       = rota_q;
  assign rotb_o       = rotb_q;
  assign busy_o       = !empty || (state_q == StHold);
  assign step_count_o = count_q;

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Directed bench for quad_encoder_gen with DWELL=16, DEPTH=4, CNT_W=8.
module tb_quad_encoder_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid = 1'b0;
  logic       dir = 1'b0;
  logic       ready, rota, rotb, busy;
  logic [7:0] count;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  quad_encoder_gen #(
    .DWELL(16),
    .DEPTH(4),
    .CNT_W(8)
  ) dut (
    .clock_i     (clk),
    .reset_ni    (rst_n),
    .step_valid_i(valid),
    .step_dir_i  (dir),
    .step_ready_o(ready),
    .rota_o      (rota),
    .rotb_o      (rotb),
    .busy_o      (busy),
    .step_count_o(count)
  );

  function automatic logic [1:0] ab(input int idx);
    case (idx & 3)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    int pushed;
    logic dirs5 [5];
    logic dirs4 [4];
    dirs5 = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    dirs4 = '{1'b1, 1'b1, 1'b0, 1'b0};

    // Reset and idle
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (100) tick();
    check("rst_ab", {rota, rotb}, 2'b00);
    check("rst_ready", ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_count", count, 8'd0);

`ifdef QUAD_DETENT_EN
    // One up step emits a full detent
    for (int t = 0; t <= 64; t++) begin
      valid = (t == 0);
      dir   = 1'b1;
      tick();
      case (t)
        1:  check("det_t1", {rota, rotb}, 2'b01);
        16: check("det_t16", {rota, rotb}, 2'b01);
        17: check("det_t17", {rota, rotb}, 2'b11);
        33: check("det_t33", {rota, rotb}, 2'b10);
        48: check("det_t48", {rota, rotb}, 2'b10);
        49: begin
          check("det_t49", {rota, rotb}, 2'b00);
          check("det_cnt", count, 8'd4);
        end
        63: check("det_busy63", busy, 1'b1);
        64: check("det_busy64", busy, 1'b0);
        default: ;
      endcase
    end
    valid = 1'b0;
`else
    // Single up step
    valid = 1'b1;
    dir   = 1'b1;
    tick();
    valid = 1'b0;
    check("one_busy_queued", busy, 1'b1);
    check("one_ab_pre", {rota, rotb}, 2'b00);
    tick();
    check("one_ab_e1", {rota, rotb}, 2'b01);
    check("one_count", count, 8'd1);
    for (int k = 2; k <= 15; k++) begin
      tick();
      check("one_ab_stable", {rota, rotb}, 2'b01);
      check("one_busy_hold", busy, 1'b1);
    end
    tick();
    check("one_busy_e16", busy, 1'b0);
    check("one_ab_e16", {rota, rotb}, 2'b01);

    // Hold valid for 10 clocks: FIFO fills, transitions 16 clocks apart
    valid = 1'b1;
    dir   = 1'b1;
    for (int t = 0; t <= 80; t++) begin
      tick();
      if (t == 9) valid = 1'b0;
      n = (t >= 1) ? ((t - 1) / 16 + 1) : 0;
      if (n > 5) n = 5;
      check("fill_ab", {rota, rotb}, ab(1 + n));
      case (t)
        1:  check("fill_ready_t1", ready, 1'b1);
        3:  check("fill_ready_t3", ready, 1'b1);
        4:  check("fill_ready_t4", ready, 1'b0);
        16: check("fill_ready_t16", ready, 1'b0);
        17: check("fill_ready_t17", ready, 1'b1);
        default: ;
      endcase
    end
    check("fill_busy_end", busy, 1'b0);
    check("fill_count", count, 8'd6);

    // Reset mid-dwell of second transition with 3 entries queued
    for (int t = 0; t <= 24; t++) begin
      valid = (t < 5);
      dir   = (t < 5) ? dirs5[t] : 1'b0;
      tick();
      if (t == 1) check("mid_t1", {rota, rotb}, 2'b10);
      if (t == 17) begin
        check("mid_t17", {rota, rotb}, 2'b11);
        check("mid_cnt17", count, 8'd8);
        check("mid_ready17", ready, 1'b1);
      end
    end
    valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_ab", {rota, rotb}, 2'b00);
    check("mid_rst_ready", ready, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_count", count, 8'd0);
    repeat (40) tick();
    check("mid_after_ab", {rota, rotb}, 2'b00);
    check("mid_after_count", count, 8'd0);
    check("mid_after_busy", busy, 1'b0);

    // up, up, down, down
    for (int t = 0; t <= 64; t++) begin
      valid = (t < 4);
      dir   = (t < 4) ? dirs4[t] : 1'b0;
      tick();
      case (t)
        1: begin
          check("uudd_t1", {rota, rotb}, 2'b01);
          check("uudd_cnt1", count, 8'd1);
        end
        16: check("uudd_t16", {rota, rotb}, 2'b01);
        17: check("uudd_t17", {rota, rotb}, 2'b11);
        33: check("uudd_t33", {rota, rotb}, 2'b01);
        48: check("uudd_t48", {rota, rotb}, 2'b01);
        49: begin
          check("uudd_t49", {rota, rotb}, 2'b00);
          check("uudd_cnt49", count, 8'd4);
        end
        63: check("uudd_busy63", busy, 1'b1);
        64: check("uudd_busy64", busy, 1'b0);
        default: ;
      endcase
    end
    valid = 1'b0;

    // 260 up steps: counter wraps, phase returns to 0
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    pushed = 0;
    valid  = 1'b1;
    dir    = 1'b1;
    for (int i = 0; i < 20000 && pushed < 260; i++) begin
      if (ready) pushed++;
      tick();
      if (pushed == 260) valid = 1'b0;
    end
    valid = 1'b0;
    check("wrap_pushed", pushed, 260);
    for (int i = 0; i < 6000 && busy; i++) begin
      tick();
    end
    check("wrap_drain", busy, 1'b0);
    check("wrap_count", count, 8'd4);
    check("wrap_ab", {rota, rotb}, 2'b00);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
